// File: rtl/obj_list_writer_if.sv
// Object edit command channel between the UI logic (master) and obj_list_writer (slave).
// Commands transfer on a rising clock edge where cmd_valid && cmd_ready.
interface obj_list_writer_if #(
  parameter int OBJ_WIDTH = 66,
  parameter int LEN_BITS  = 6
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [LEN_BITS-1:0]  cmd_index;
  logic [OBJ_WIDTH-1:0] cmd_obj;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_obj,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_obj,
    output cmd_ready
  );
endinterface

// File: rtl/obj_list_writer.sv
// Double-buffered scene list: edits land in a shadow list, and a frame_sync commits the
// whole shadow list to the active list in one cycle so the renderer never sees a half edit.
module obj_list_writer #(
  parameter int OBJ_WIDTH = 66,
  parameter int MAX_LEN   = 16,
  parameter int LEN_BITS  = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  obj_list_writer_if.slave               cmd,
  input  logic                           frame_sync,
  output logic [OBJ_WIDTH*MAX_LEN-1:0]   obj_arr_packed,
  output logic [LEN_BITS-1:0]            obj_arr_len,
  output logic [LEN_BITS-1:0]            shadow_len,
  output logic                           busy,
  output logic                           commit_done,
  output logic                           err_full,
  output logic                           err_index
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_BITS-1:0] FULL_LEN = LEN_BITS'(MAX_LEN);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_COMMIT} state_t;
  typedef enum logic [1:0] {OP_APPEND, OP_WRITE, OP_CLEAR, OP_POP} op_t;

  state_t               state_q;
  logic [OBJ_WIDTH-1:0] shadow_q [MAX_LEN];
  logic [OBJ_WIDTH-1:0] active_q [MAX_LEN];
  logic [LEN_BITS-1:0]  shadow_len_q;
  logic [LEN_BITS-1:0]  active_len_q;
  logic [IDX_W-1:0]     clr_idx_q;
  logic                 dirty_q, dirty_d;
  logic                 pending_q, pending_d;
  logic                 commit_done_q, err_full_q, err_index_q;
  logic                 accept;
  logic [IDX_W-1:0]     pop_idx;

  assign cmd.cmd_ready = !rst && (state_q == ST_IDLE) && !pending_q;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  // Index of the last live entry; when the list is full the low bits wrap to MAX_LEN-1.
  assign pop_idx       = shadow_len_q[IDX_W-1:0] - IDX_W'(1);

  // A frame_sync only matters if something changed, including a command landing on the same edge.
  always_comb begin
    dirty_d   = dirty_q | accept;
    pending_d = pending_q | (frame_sync & (dirty_q | accept));
    if (state_q == ST_IDLE && pending_q) begin
      dirty_d   = 1'b0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shadow_len_q  <= '0;
      active_len_q  <= '0;
      clr_idx_q     <= '0;
      dirty_q       <= 1'b0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      err_full_q    <= 1'b0;
      err_index_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      dirty_q       <= dirty_d;
      pending_q     <= pending_d;
      commit_done_q <= 1'b0;
      err_full_q    <= 1'b0;
      err_index_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            for (int i = 0; i < MAX_LEN; i++) active_q[i] <= shadow_q[i];
            active_len_q  <= shadow_len_q;
            commit_done_q <= 1'b1;
            state_q       <= ST_COMMIT;
          end else if (accept) begin
            case (op_t'(cmd.cmd_op))
              OP_APPEND: begin
                if (shadow_len_q < FULL_LEN) begin
                  shadow_q[shadow_len_q[IDX_W-1:0]] <= cmd.cmd_obj;
                  shadow_len_q <= shadow_len_q + LEN_BITS'(1);
                end else begin
                  err_full_q <= 1'b1;
                end
              end
              OP_WRITE: begin
                if (cmd.cmd_index < shadow_len_q) begin
                  shadow_q[cmd.cmd_index[IDX_W-1:0]] <= cmd.cmd_obj;
                end else begin
                  err_index_q <= 1'b1;
                end
              end
              OP_CLEAR: begin
                shadow_len_q <= '0;
                clr_idx_q    <= '0;
                state_q      <= ST_CLEAR;
              end
              OP_POP: begin
                if (shadow_len_q != '0) begin
                  shadow_q[pop_idx] <= '0;
                  shadow_len_q      <= shadow_len_q - LEN_BITS'(1);
                end else begin
                  err_index_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_CLEAR: begin
          shadow_q[clr_idx_q] <= '0;
          clr_idx_q           <= clr_idx_q + IDX_W'(1);
          if (clr_idx_q == LAST_IDX) state_q <= ST_IDLE;
        end
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign obj_arr_packed[g*OBJ_WIDTH +: OBJ_WIDTH] = active_q[g];
  end

  assign obj_arr_len = active_len_q;
  assign shadow_len  = shadow_len_q;
  assign busy        = (state_q != ST_IDLE);
  assign commit_done = commit_done_q;
  assign err_full    = err_full_q;
  assign err_index   = err_index_q;

endmodule

// File: tb/tb_obj_list_writer.sv
// Directed bench for obj_list_writer: table of edit commands with hand-computed lengths and
// error pulses, plus hand-written sequences for commit timing, CLEAR, and reset abort.
module tb_obj_list_writer;
  localparam int W = 66;
  localparam int N = 16;
  localparam int L = 6;
  localparam logic [1:0] APPEND = 2'd0, WRITE = 2'd1, CLEAR = 2'd2, POP = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic frame_sync;
  logic [W*N-1:0] obj_arr_packed;
  logic [L-1:0] obj_arr_len, shadow_len;
  logic busy, commit_done, err_full, err_index;

  obj_list_writer_if #(.OBJ_WIDTH(W), .LEN_BITS(L)) cmd_if ();

  obj_list_writer #(.OBJ_WIDTH(W), .MAX_LEN(N), .LEN_BITS(L)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .frame_sync(frame_sync),
    .obj_arr_packed(obj_arr_packed), .obj_arr_len(obj_arr_len), .shadow_len(shadow_len),
    .busy(busy), .commit_done(commit_done), .err_full(err_full), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_sh [N];
  int m_len = 0;

  typedef struct {
    logic [1:0]   op;
    int           idx;
    logic [W-1:0] obj;
    int           exp_len;
    bit           ef;
    bit           ei;
    bit           commit;
  } vec_t;
  vec_t vecs [10];

  function automatic logic [W-1:0] mk(input logic [3:0] t, input logic [9:0] x, input logic [9:0] y,
                                      input logic [9:0] w, input logic [9:0] h, input logic [9:0] r,
                                      input logic [11:0] c);
    return {t, x, y, w, h, r, c};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_cmd(input logic [1:0] op, input int idx, input logic [W-1:0] obj);
    case (op)
      APPEND: if (m_len < N) begin m_sh[m_len] = obj; m_len++; end
      WRITE:  if (idx < m_len) m_sh[idx] = obj;
      CLEAR:  begin m_len = 0; for (int i = 0; i < N; i++) m_sh[i] = '0; end
      default: if (m_len > 0) begin m_len--; m_sh[m_len] = '0; end
    endcase
  endtask

  task automatic do_cmd(input logic [1:0] op, input int idx, input logic [W-1:0] obj);
    int n = 0;
    while (!cmd_if.cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_if.cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_index = L'(idx);
    cmd_if.cmd_obj   = obj;
    tick();
    cmd_if.cmd_valid = 1'b0;
    model_cmd(op, idx, obj);
  endtask

  task automatic check_active(input string tag);
    check({tag, "_len"}, obj_arr_len, m_len);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_entry%0d", tag, i), obj_arr_packed[i*W +: W], m_sh[i]);
  endtask

  task automatic do_commit(input string tag);
    int n = 0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    while (!commit_done && n < 40) begin tick(); n++; end
    check({tag, "_commit_done"}, commit_done, 1'b1);
    check_active(tag);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      do_cmd(vecs[r].op, vecs[r].idx, vecs[r].obj);
      check($sformatf("row%0d_shadow_len", r), shadow_len, vecs[r].exp_len);
      check($sformatf("row%0d_err_full", r), err_full, vecs[r].ef);
      check($sformatf("row%0d_err_index", r), err_index, vecs[r].ei);
      if (vecs[r].commit) do_commit($sformatf("row%0d", r));
    end
  endtask

  logic [W-1:0] rect, circ, tri_o, white, obj16, objx;
  int busy_cnt, ready_bad, seen;

  initial begin
    rect  = mk(4'd1, 10'd100, 10'd100, 10'd40, 10'd40, 10'd0, 12'h0f0);
    circ  = mk(4'd2, 10'd300, 10'd200, 10'd0, 10'd0, 10'd25, 12'hf00);
    tri_o = mk(4'd3, 10'd10, 10'd20, 10'd30, 10'd40, 10'd5, 12'h00f);
    white = mk(4'hb, 10'd50, 10'd60, 10'd70, 10'd80, 10'd0, 12'hfff);
    objx  = mk(4'd2, 10'd7, 10'd8, 10'd0, 10'd0, 10'd9, 12'h123);
    vecs[0] = '{APPEND, 0, rect,  1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{APPEND, 0, circ,  2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{APPEND, 0, tri_o, 3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{WRITE,  1, white, 3, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{WRITE,  3, circ,  3, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{POP,    0, '0,    2, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{POP,    0, '0,    1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{POP,    0, '0,    0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{POP,    0, '0,    0, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{WRITE,  0, rect,  0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < N; i++) m_sh[i] = '0;

    rst = 1'b1; frame_sync = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = '0; cmd_if.cmd_index = '0; cmd_if.cmd_obj = '0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_if.cmd_ready, 1'b0);
    check("rst_shadow_len", shadow_len, 0);
    check("rst_obj_arr_len", obj_arr_len, 0);
    check("rst_packed_zero", obj_arr_packed == '0, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {commit_done, err_full, err_index}, 3'b000);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_if.cmd_ready, 1'b1);

    // Two appends, nothing committed until frame_sync; commit_done two cycles after it.
    run_rows(0, 1);
    check("t1_active_len_before", obj_arr_len, 0);
    check("t1_packed_before", obj_arr_packed == '0, 1'b1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("t1_commit_done_early", commit_done, 1'b0);
    check("t1_ready_pending", cmd_if.cmd_ready, 1'b0);
    tick();
    check("t1_commit_done", commit_done, 1'b1);
    check("t1_busy_commit", busy, 1'b1);
    check("t1_entry0_rect", obj_arr_packed[0 +: W], rect);
    check("t1_entry1_circ", obj_arr_packed[W +: W], circ);
    check_active("t1");
    tick();
    check("t1_commit_done_pulse", commit_done, 1'b0);

    // WRITE / POP behaviour, including dropped commands.
    run_rows(2, 9);

    // 17 appends: the last one is dropped with a single err_full pulse.
    busy_cnt = 0;
    for (int k = 0; k < N; k++) begin
      obj16 = mk(4'(k % 3 + 1), 10'(k * 10), 10'(k * 5), 10'd4, 10'd4, 10'd2, 12'(k * 17));
      do_cmd(APPEND, 0, obj16);
      if (shadow_len != L'(k + 1) || err_full) busy_cnt++;
    end
    check("t2_fill_bad_steps", busy_cnt, 0);
    do_cmd(APPEND, 0, objx);
    check("t2_len_full", shadow_len, N);
    check("t2_err_full", err_full, 1'b1);
    tick();
    check("t2_err_full_single", err_full, 1'b0);
    do_commit("t2");
    check("t2_entry15", obj_arr_packed[15*W +: W], obj16);

    // CLEAR from a full list with frame_sync three cycles in; commit waits for CLEAR to finish.
    do_cmd(CLEAR, 0, '0);
    busy_cnt = 0; ready_bad = 0;
    for (int i = 0; i < 40; i++) begin
      frame_sync = (i == 3);
      if (!busy) break;
      busy_cnt++;
      if (cmd_if.cmd_ready) ready_bad++;
      if (i > 0 && commit_done) ready_bad++;
      tick();
    end
    frame_sync = 1'b0;
    check("t4_clear_cycles", busy_cnt, N);
    check("t4_ready_low", ready_bad, 0);
    check("t4_shadow_len", shadow_len, 0);
    check("t4_active_kept", obj_arr_len, N);
    check("t4_no_commit_yet", commit_done, 1'b0);
    tick();
    check("t4_commit_done", commit_done, 1'b1);
    check("t4_packed_zero", obj_arr_packed == '0, 1'b1);
    check_active("t4");
    tick();

    // APPEND in the same cycle as frame_sync is part of the commit.
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = APPEND; cmd_if.cmd_obj = circ;
    frame_sync = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0; frame_sync = 1'b0;
    model_cmd(APPEND, 0, circ);
    check("t5_shadow_len", shadow_len, 1);
    tick();
    check("t5_commit_done", commit_done, 1'b1);
    check("t5_entry0", obj_arr_packed[0 +: W], circ);
    check("t5_len", obj_arr_len, 1);
    // frame_sync during COMMIT and then while clean: no further commit.
    frame_sync = 1'b1;
    tick();
    tick();
    frame_sync = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (commit_done) seen++;
      tick();
    end
    check("t5_no_spurious_commit", seen, 0);

    // Reset in the middle of CLEAR aborts everything.
    do_cmd(APPEND, 0, rect);
    do_commit("t6_pre");
    do_cmd(CLEAR, 0, '0);
    tick();
    check("t6_in_clear", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("t6_busy", busy, 1'b0);
    check("t6_obj_arr_len", obj_arr_len, 0);
    check("t6_shadow_len", shadow_len, 0);
    check("t6_packed_zero", obj_arr_packed == '0, 1'b1);
    check("t6_ready_in_rst", cmd_if.cmd_ready, 1'b0);
    check("t6_pulses", {commit_done, err_full, err_index}, 3'b000);
    rst = 1'b0;
    #1;
    check("t6_ready_after", cmd_if.cmd_ready, 1'b1);
    m_len = 0;
    for (int i = 0; i < N; i++) m_sh[i] = '0;
    do_cmd(APPEND, 0, tri_o);
    do_commit("t6_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
